// File: rtl/fsm.sv
// Temperature-supervision controller (Moore).
// Tracks IDLE / MONITOR / VENTILADOR / ALARMA from the threshold flags and
// drives registered fan and alarm enables that change together with estado.
module fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       ac_ventilador,
  input  logic       ac_alarma,
  input  logic       lectura,
  output logic       en_alarma,
  output logic       en_ventilador,
  output logic [1:0] estado
);

  localparam logic [1:0] IDLE       = 2'b00;
  localparam logic [1:0] MONITOR    = 2'b01;
  localparam logic [1:0] VENTILADOR = 2'b10;
  localparam logic [1:0] ALARMA     = 2'b11;

  logic [1:0] state_q, state_d;

  // Next-state: en=0 dominates; flags are only looked at when lectura=1.
  // In every active state a fresh reading selects the level it demands,
  // with ac_alarma taking priority over ac_ventilador.
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = MONITOR;
        MONITOR: begin
          if (lectura) begin
            if (ac_alarma)          state_d = ALARMA;
            else if (ac_ventilador) state_d = VENTILADOR;
          end
        end
        VENTILADOR: begin
          if (lectura) begin
            if (ac_alarma)          state_d = ALARMA;
            else if (!ac_ventilador) state_d = MONITOR;
          end
        end
        ALARMA: begin
          if (lectura && !ac_alarma)
            state_d = ac_ventilador ? VENTILADOR : MONITOR;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers; outputs are decoded from the next state so
  // they land on the same edge as estado without any input-to-output path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      en_ventilador <= 1'b0;
      en_alarma     <= 1'b0;
    end else begin
      state_q       <= state_d;
      en_ventilador <= state_d[1];
      en_alarma     <= &state_d;
    end
  end

  assign estado = state_q;

endmodule

// File: tb/tb_fsm.sv
// Bench for the temperature-supervision controller: directed walk through
// every path followed by randomized traffic against a level-based model.
module tb_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       ac_ventilador = 1'b0;
  logic       ac_alarma = 1'b0;
  logic       lectura = 1'b0;
  logic       en_alarma, en_ventilador;
  logic [1:0] estado;

  int n_assert = 0;
  int n_fail = 0;
  // Model level: 0 idle, 1 watching, 2 fan on, 3 fan and alarm on.
  int lvl = 0;

  fsm dut (
    .clk(clk), .rst(rst), .en(en), .ac_ventilador(ac_ventilador),
    .ac_alarma(ac_alarma), .lectura(lectura), .en_alarma(en_alarma),
    .en_ventilador(en_ventilador), .estado(estado)
  );

  always #5 clk = ~clk;

  // A fresh reading jumps straight to the level the flags demand.
  function automatic int model_next(int cur);
    if (!rst || !en) return 0;
    if (cur == 0) return 1;
    if (lectura) return ac_alarma ? 3 : (ac_ventilador ? 2 : 1);
    return cur;
  endfunction

  task automatic cyc();
    int n;
    n = model_next(lvl);
    @(posedge clk);
    lvl = n;
    #1;
  endtask

  task automatic chk(input string tag, input int exp_lvl);
    logic [3:0] got, exp;
    got = {estado, en_ventilador, en_alarma};
    exp = {exp_lvl[1:0], (exp_lvl >= 2) ? 1'b1 : 1'b0, (exp_lvl == 3) ? 1'b1 : 1'b0};
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: estado/fan/alarm got %b_%b_%b expected %b_%b_%b", tag,
             got[3:2], got[1], got[0], exp[3:2], exp[1], exp[0]);
    end
  endtask

  task automatic drive(input logic e, input logic av, input logic aa, input logic l);
    en = e; ac_ventilador = av; ac_alarma = aa; lectura = l;
  endtask

  initial begin
    // Reset asserted with every input active: outputs cleared before any edge.
    drive(1, 1, 1, 1);
    #2;
    chk("reset_async", 0);
    cyc(); cyc();
    chk("reset_hold", 0);

    // Enable / disable.
    rst = 1'b1;
    drive(1, 0, 0, 0);
    cyc(); chk("en_to_monitor", 1);
    en = 0;
    cyc(); chk("en_off_idle", 0);
    en = 1;
    cyc(); chk("en_again", 1);

    // Fan path: flags ignored while lectura=0.
    drive(1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(); chk("no_lectura_hold", 1);
    end
    lectura = 1;
    cyc(); chk("fan_on", 2);
    cyc(); chk("fan_stable_lectura_held", 2);
    ac_ventilador = 0;
    cyc(); chk("fan_off", 1);

    // Alarm path.
    ac_ventilador = 1;
    cyc(); chk("fan_on_2", 2);
    ac_alarma = 1;
    cyc(); chk("alarm_on", 3);
    cyc(); chk("alarm_stable", 3);
    ac_alarma = 0; ac_ventilador = 1;
    cyc(); chk("alarm_to_fan", 2);
    ac_ventilador = 0;
    cyc(); chk("fan_to_monitor", 1);

    // Direct alarm with fan flag low.
    drive(1, 0, 1, 1);
    cyc(); chk("direct_alarm", 3);
    drive(1, 0, 0, 0);
    cyc(); chk("alarm_no_lectura_hold", 3);

    // en=0 overrides an active alarm reading.
    drive(0, 1, 1, 1);
    cyc(); chk("en_override", 0);

    // Mid-cycle reset in VENTILADOR clears outputs at once.
    drive(1, 0, 0, 0);
    cyc(); chk("re_enable", 1);
    drive(1, 1, 0, 1);
    cyc(); chk("fan_before_rst", 2);
    #2;
    rst = 1'b0;
    lvl = 0;
    #1;
    chk("rst_mid_cycle", 0);
    #3;
    rst = 1'b1;
    drive(0, 1, 1, 1);
    cyc(); chk("post_rst_needs_en", 0);
    en = 1;
    cyc(); chk("post_rst_en", 1);

    // Randomized traffic, with occasional disable and reset.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) != 0);
      en  = ($urandom_range(0, 19) != 0);
      ac_ventilador = $urandom_range(0, 1);
      ac_alarma     = ($urandom_range(0, 2) == 0);
      lectura       = ($urandom_range(0, 2) != 0);
      if (!rst) begin
        #1;
        lvl = 0;
        chk("rand_async_rst", 0);
      end
      cyc();
      chk("rand", lvl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
